// File: rtl/fifo_ctrl_if.sv
// Handshake and memory-side bundle for the FIFO controller.
// master = the controller itself, slave = producer/consumer/memory environment.
interface fifo_ctrl_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [N:0]   count;
    logic         full;
    logic         empty;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;

    modport master (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, count, full, empty,
               mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, count, full, empty,
               mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Ring-buffer FIFO controller in front of a single-port synchronous RAM.
// Writes and reads share the one RAM port; a read issue takes priority and
// stalls the producer for that cycle. The head entry is held in a registered
// output stage so the consumer sees data without RAM read latency.
module fifo_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    fifo_ctrl_if.master  bus
);
    localparam logic [N:0]   DEPTH   = {1'b1, {N{1'b0}}};
    localparam logic [N:0]   CNT_ONE = {{N{1'b0}}, 1'b1};
    localparam logic [N-1:0] PTR_ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] wr_ptr;
    logic [N-1:0] rd_ptr;
    logic [N:0]   mem_cnt;
    logic         out_valid_q;
    logic [N-1:0] out_data_q;

    logic full;
    logic in_ready;
    logic push;
    logic pop;
    logic start_read;

    // Handshake decode and read-issue decision; a push accepted this cycle
    // counts as available data so the first word is read on the next cycle.
    always_comb begin
        full       = (mem_cnt == DEPTH);
        in_ready   = !full && (state != RD_ISSUE);
        push       = bus.in_valid && in_ready;
        pop        = out_valid_q && bus.out_ready;
        start_read = (state == IDLE) && (!out_valid_q || pop) &&
                     ((mem_cnt != '0) || push);
    end

    assign bus.in_ready  = in_ready;
    assign bus.full      = full;
    assign bus.count     = mem_cnt + {{N{1'b0}}, out_valid_q};
    assign bus.empty     = (mem_cnt == '0) && !out_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.mem_we    = push;
    assign bus.mem_addr  = push ? wr_ptr : rd_ptr;
    assign bus.mem_wdata = bus.in_data;

    // Sequencer, pointers, occupancy and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (push) begin
                mem_cnt <= mem_cnt + CNT_ONE;
            end else if (state == RD_ISSUE) begin
                mem_cnt <= mem_cnt - CNT_ONE;
            end

            if (state == CAPTURE) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.mem_rdata;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_read) begin
                        state <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural RAM and a queue-based
// reference model of FIFO contents.
module tb_fifo_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_ctrl_if #(.N(N)) bus ();

    fifo_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Behavioural single-port RAM: write on we, otherwise registered read.
    logic [N-1:0] mem [0:(2**N)-1];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else            bus.mem_rdata     <= mem[bus.mem_addr];
    end

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q [$];
    logic [7:0] wr_addr_model;
    logic       last_acc;
    logic       last_pop;
    logic       last_in_ready;
    logic       last_full;
    int         pop_total;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, sample before the rising edge.
    task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy);
        int held;
        int cnt;
        logic [7:0] exp_data;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        last_in_ready = bus.in_ready;
        last_full     = bus.full;
        last_acc      = iv && bus.in_ready;
        last_pop      = bus.out_valid && ordy;
        held = model_q.size();
        cnt  = int'(bus.count);
        checkOutput("mem_we", {31'd0, bus.mem_we}, {31'd0, last_acc});
        if (last_acc) checkOutput("wr_addr", {24'd0, bus.mem_addr}, {24'd0, wr_addr_model});
        checkOutput("count_range", {31'd0, (cnt <= held) && (held - cnt <= 1)}, 32'd1);
        if (held == 0) checkOutput("empty_when_none", {31'd0, bus.empty}, 32'd1);
        if (held >= 2) checkOutput("not_empty", {31'd0, bus.empty}, 32'd0);
        if (held < 256) checkOutput("not_full", {31'd0, bus.full}, 32'd0);
        if (bus.full === 1'b1) checkOutput("full_blocks", {31'd0, bus.in_ready}, 32'd0);
        if (last_pop) begin
            if (held == 0) begin
                checkOutput("pop_unexpected", 32'd1, 32'd0);
            end else begin
                exp_data = model_q.pop_front();
                checkOutput("pop_data", {24'd0, bus.out_data}, {24'd0, exp_data});
                pop_total++;
            end
        end
        if (last_acc) begin
            model_q.push_back(d);
            wr_addr_model = wr_addr_model + 8'd1;
        end
    endtask

    task automatic drainAll(input string tag);
        int cyc = 0;
        while ((model_q.size() != 0) && (cyc < 3000)) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            cyc++;
        end
        checkOutput(tag, model_q.size(), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput({tag, "_count"}, {23'd0, bus.count}, 32'd0);
        checkOutput({tag, "_empty"}, {31'd0, bus.empty}, 32'd1);
    endtask

    initial begin
        int cyc;
        int k;
        logic prev_stall;
        logic stall;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        wr_addr_model = 8'd0;
        pop_total = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Traffic, then a mid-operation reset held one cycle
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        model_q.delete();
        wr_addr_model = 8'd0;
        #1;
        checkOutput("rst_count", {23'd0, bus.count}, 32'd0);
        checkOutput("rst_empty", {31'd0, bus.empty}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("rst_full", {31'd0, bus.full}, 32'd0);

        // Single entry latency
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("se_c0_addr", {24'd0, bus.mem_addr}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("se_c1_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("se_c1_addr", {24'd0, bus.mem_addr}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("se_c2_out_valid", {31'd0, bus.out_valid}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("se_c3_out_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("se_c3_out_data", {24'd0, bus.out_data}, 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("se_c4_empty", {31'd0, bus.empty}, 32'd1);
        checkOutput("se_c4_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Ordering 0x01..0x10
        k = 1;
        cyc = 0;
        while ((k <= 16) && (cyc < 200)) begin
            applyStimulus(1'b1, 8'(k), 1'b0);
            if (last_acc) k++;
            cyc++;
        end
        checkOutput("ord_pushed", k, 32'd17);
        pop_total = 0;
        drainAll("ord_drain");
        checkOutput("ord_pops", pop_total, 32'd16);

        // Full: 257 entries with consumer stalled
        cyc = 0;
        while ((model_q.size() < 257) && (cyc < 1000)) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0);
            cyc++;
        end
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("full_count", {23'd0, bus.count}, 32'd257);
        checkOutput("full_flag", {31'd0, bus.full}, 32'd1);
        checkOutput("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("full_extra_ignored", {31'd0, last_acc}, 32'd0);
        checkOutput("full_count_hold", {23'd0, bus.count}, 32'd257);
        drainAll("full_drain");

        // Wrap: 300 values interleaved with random handshakes
        k = 0;
        cyc = 0;
        while ((k < 300) && (cyc < 5000)) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'(k), 1'($urandom_range(0, 1)));
            if (last_acc) k++;
            cyc++;
        end
        checkOutput("wrap_pushed", k, 32'd300);
        drainAll("wrap_drain");

        // Contention: producer and consumer always active
        k = 0;
        cyc = 0;
        prev_stall = 1'b0;
        pop_total = 0;
        while ((k < 1000) && (cyc < 20000)) begin
            applyStimulus(1'b1, 8'($urandom), 1'b1);
            stall = !last_in_ready && !last_full;
            if (stall) begin
                checkOutput("stall_single_cycle", {31'd0, prev_stall}, 32'd0);
                checkOutput("stall_no_write", {31'd0, bus.mem_we}, 32'd0);
            end
            prev_stall = stall;
            if (last_acc) k++;
            cyc++;
        end
        checkOutput("cont_pushed", k, 32'd1000);
        drainAll("cont_drain");
        checkOutput("cont_pops", pop_total, 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
